batchnorm2d_seq: RTL

Sequential, stream-based per-channel batch-norm engine for feature maps of CH×IN_H×IN_W fixed-point elements. A controller FSM sequences one shared multiply-add-round pipeline over every element, selecting that channel's scale and bias from an on-block parameter register file loaded over a config port. It sits between streaming conv/pool stages and replaces the fully parallel batch-norm array where area matters. Results are bit-exact with the parallel array.

---
 rtl/batchnorm2d_seq.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/batchnorm2d_seq.sv
// batchnorm2d_seq: sequential per-channel batch-norm over a CH x IN_H x IN_W element stream.
// Optional macro BATCHNORM2D_SEQ_SAT_EN saturates the stage-2 result instead of wrapping it.
module batchnorm2d_seq #(
  parameter int CH    = 1,
  parameter int IN_H  = 1,
  parameter int IN_W  = 1,
  parameter int WIDTH = 16,
  parameter int FRAC  = 8,
  localparam int CW   = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic             cfg_sel,
  input  logic [CW-1:0]    cfg_addr,
  input  logic [WIDTH-1:0] cfg_data,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    out_ch
);
  localparam int NPIX = IN_H * IN_W;
  localparam int PW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int AW   = 2 * WIDTH + 1;
  localparam logic [PW-1:0] PIX_MAX = PW'(NPIX - 1);
  localparam logic [CW-1:0] CH_MAX  = CW'(CH - 1);
  localparam int HS = (FRAC > 0) ? FRAC - 1 : 0;
  localparam logic [AW-1:0] HALF = (FRAC > 0) ? (AW'(1) << HS) : '0;

  // state | meaning
  // IDLE  | waiting for start; config writes accepted
  // RUN   | accepting input elements
  // DRAIN | all elements accepted, pipeline emptying
  // DONE  | one-cycle completion pulse
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state;

  logic signed [WIDTH-1:0] scale_r [2**CW];
  logic signed [WIDTH-1:0] bias_r  [2**CW];
  logic [PW-1:0] pix;
  logic [CW-1:0] ch;
  logic          v1, v2;
  logic signed [AW-1:0] acc1;
  logic [CW-1:0]        ch1;
  logic                 stall, accept, last_elem;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [AW-1:0]      acc, mag, rnd;
  logic [WIDTH-1:0]          narrow;
  logic signed [WIDTH-1:0]   bsel;

  assign stall     = out_valid && !out_ready;
  assign in_ready  = (state == RUN) && !stall;
  assign accept    = in_valid && in_ready;
  assign last_elem = (pix == PIX_MAX) && (ch == CH_MAX);
  assign out_valid = v2;

`ifdef BATCHNORM2D_SEQ_SAT_EN
  localparam logic signed [AW-1:0] SMAX = {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] SMIN = ~SMAX;
  logic signed [AW-1:0] res;
`endif

  always_comb begin
    bsel = bias_r[ch];
    prod = $signed(in_data) * scale_r[ch];
    acc  = {{(AW-2*WIDTH){prod[2*WIDTH-1]}}, prod}
         + ({{(AW-WIDTH){bsel[WIDTH-1]}}, bsel} <<< FRAC);
    // Round half away from zero on the magnitude, then restore the sign.
    mag  = acc1[AW-1] ? -acc1 : acc1;
    rnd  = (mag + HALF) >> FRAC;
`ifdef BATCHNORM2D_SEQ_SAT_EN
    res  = acc1[AW-1] ? -rnd : rnd;
    if (res > SMAX)      narrow = SMAX[WIDTH-1:0];
    else if (res < SMIN) narrow = SMIN[WIDTH-1:0];
    else                 narrow = res[WIDTH-1:0];
`else
    narrow = WIDTH'(acc1[AW-1] ? -rnd : rnd);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2**CW; i++) begin
        scale_r[i] <= '0;
        bias_r[i]  <= '0;
      end
    end else if (cfg_we && state == IDLE && ({1'b0, cfg_addr} < (CW+1)'(CH))) begin
      if (cfg_sel) bias_r[cfg_addr]  <= cfg_data;
      else         scale_r[cfg_addr] <= cfg_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1       <= 1'b0;
      v2       <= 1'b0;
      acc1     <= '0;
      ch1      <= '0;
      out_data <= '0;
      out_ch   <= '0;
    end else if (!stall) begin
      v1 <= accept;
      if (accept) begin
        acc1 <= acc;
        ch1  <= ch;
      end
      v2 <= v1;
      if (v1) begin
        out_data <= narrow;
        out_ch   <= ch1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pix   <= '0;
      ch    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= RUN;
          busy  <= 1'b1;
          pix   <= '0;
          ch    <= '0;
        end
        RUN: if (accept) begin
          if (pix == PIX_MAX) begin
            pix <= '0;
            ch  <= ch + 1'b1;
          end else begin
            pix <= pix + 1'b1;
          end
          if (last_elem) state <= DRAIN;
        end
        // Leave on the edge that retires the final output so done follows it directly.
        DRAIN: if (!v1 && (!v2 || out_ready)) begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
